scr1_tb_add_evt_buf: RTL and testbench
======================================

// Module: scr1_tb_add_evt_buf
// PURPOSE
//  Testbench-side buffer downstream of the ADD-instruction detector on the IMEM AHB response path.
//  Accepts one detected-ADD event per cycle (register indices plus operand values) and tags it with a sequence number.
//  Queues events in a FIFO and drains them to a log sink over a valid/ready handshake.
//  Keeps total and dropped event counters, so bursts of ADDs are never silently lost when the sink stalls.
// PARAMETERS
//  DEPTH   8   FIFO entries; power of two, >= 2
//  XLEN    32  operand value width
//  SEQ_W   16  sequence-number width; wraps modulo 2^SEQ_W
//  CNT_W   32  event/drop counter width; saturating
// PORTS
//  clk           in   1      core clock, same as imem AHB bridge clock
//  rst           in   1      asynchronous, active-high reset
//  evt_vld       in   1      detector reports an ADD this cycle
//  evt_rs1_idx   in   5      rs1 index (instr[19:15])
//  evt_rs2_idx   in   5      rs2 index (instr[24:20])
//  evt_rs1_val   in   XLEN   MPRF value of rs1
//  evt_rs2_val   in   XLEN   MPRF value of rs2
//  cnt_clr       in   1      synchronous clear of counters, seq and sticky overflow
//  log_vld       out  1      head entry valid
//  log_rdy       in   1      sink accepts head entry
//  log_seq       out  SEQ_W  sequence number of head entry
//  log_rs1_idx   out  5      head rs1 index
//  log_rs2_idx   out  5      head rs2 index
//  log_rs1_val   out  XLEN   head rs1 value
//  log_rs2_val   out  XLEN   head rs2 value
//  evt_cnt       out  CNT_W  events accepted into FIFO
//  drop_cnt      out  CNT_W  events dropped because FIFO was full
//  ovf_sticky    out  1      set on first drop; held until cnt_clr or rst
// BEHAVIOUR
//  - Reset: FIFO empty, log_vld=0, all log_* data=0, seq=0, evt_cnt=0, drop_cnt=0, ovf_sticky=0.
//  - Push: evt_vld & (!full | pop). Entry is written with the current seq, then seq increments.
//  - Pop: log_vld & log_rdy. The head advances on the same edge.
//  - Show-ahead output: log_* reflect the head entry combinationally from storage.
//    Latency: event pushed at edge N gives log_vld=1 after edge N; no bypass in the same cycle.
//  - Full + push + pop in the same cycle: push is accepted, occupancy is unchanged, no drop.
//  - Full + push without pop: event is discarded, drop_cnt+1 (saturating), ovf_sticky<=1, seq unchanged.
//  - Empty + pop: impossible, since log_vld=0; log_rdy is ignored when empty.
//  - Pointers are log2(DEPTH)+1 bits.
//    full = MSBs differ and LSBs equal; empty = pointers equal; wrap is natural modulo.
//  - log_vld and log_* are held stable while log_vld & !log_rdy. Sink may assert rdy at any time.
//  - evt_cnt increments per accepted push and saturates at all-ones. Neither counter wraps.
//  - cnt_clr: in that cycle evt_cnt, drop_cnt, seq and ovf_sticky go to 0.
//    A simultaneous push is still stored, with seq=0, and leaves evt_cnt=1.
//    FIFO contents and pointers are untouched.
//  - rst mid-operation: all state clears asynchronously and pending entries are lost.
//    First post-reset event gets seq=0.
// STRUCTURE
//  - Package scr1_tb_evt_pkg holds:
//    typedef struct packed {seq, rs1_idx, rs2_idx, rs1_val, rs2_val} type_scr1_add_evt_s
//    localparam SCR1_TB_EVT_IDX_W=5
//  - Sub-module scr1_tb_evt_fifo: generic show-ahead sync FIFO (DEPTH, type/width param, async rst), with push/pop/full/empty.
//  - Top level holds the seq counter, saturating counters, sticky flag and drop logic.
// TESTING
//  1. Reset, 3 events (rs1=1/val=5, rs2=2/val=7 ...) with log_rdy=1 -> log seq 0,1,2 one cycle after each push; evt_cnt=3, drop_cnt=0.
//  2. log_rdy=0, DEPTH=8, 10 back-to-back events -> 8 stored, drop_cnt=2, ovf_sticky=1; draining yields seq 0..7 in order.
//  3. FIFO full, evt_vld & log_rdy same cycle -> no drop, occupancy stays 8, new entry seq=8 appears last.
//  4. Head held with log_rdy=0 for 5 cycles -> log_* unchanged throughout; pops on the first rdy cycle.
//  5. SEQ_W=4, 20 events drained live -> seq wraps 15->0; evt_cnt=20.
//  6. cnt_clr with simultaneous push, then rst during a non-empty FIFO -> stored seq=0, evt_cnt=1; after rst log_vld=0 and all counters 0.

Source files
------------

// File: rtl/scr1_tb_evt_pkg.sv
// Shared types and widths for the ADD-event buffer that sits behind the IMEM ADD detector.
package scr1_tb_evt_pkg;

  localparam int unsigned SCR1_TB_EVT_IDX_W  = 5;
  localparam int unsigned SCR1_TB_EVT_SEQ_W  = 16;
  localparam int unsigned SCR1_TB_EVT_XLEN   = 32;

  // Default-width event record for log consumers
  typedef struct packed {
    logic [SCR1_TB_EVT_SEQ_W-1:0] seq;
    logic [SCR1_TB_EVT_IDX_W-1:0] rs1_idx;
    logic [SCR1_TB_EVT_IDX_W-1:0] rs2_idx;
    logic [SCR1_TB_EVT_XLEN-1:0]  rs1_val;
    logic [SCR1_TB_EVT_XLEN-1:0]  rs2_val;
  } type_scr1_add_evt_s;

endpackage

// File: rtl/scr1_tb_evt_fifo.sv
// Generic show-ahead synchronous FIFO; head data reads straight from storage, zero when empty.
module scr1_tb_evt_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter type         T     = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  T     wdata,
  output T     rdata,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wptr_q;
  logic [AW:0] rptr_q;
  T            mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + (AW+1)'(1);
      if (pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  // On full+push+pop the write lands in the slot being vacated by the head
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q[AW-1:0]] <= wdata;
  end

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata = empty ? T'('0) : mem[rptr_q[AW-1:0]];

endmodule

// File: rtl/scr1_tb_add_evt_buf.sv
// Tags detected ADD events with a sequence number, queues them and drains them to a log sink,
// counting accepted and dropped events so sink stalls never lose data silently.
module scr1_tb_add_evt_buf
  import scr1_tb_evt_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned SEQ_W = 16,
  parameter int unsigned CNT_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         evt_vld,
  input  logic [SCR1_TB_EVT_IDX_W-1:0] evt_rs1_idx,
  input  logic [SCR1_TB_EVT_IDX_W-1:0] evt_rs2_idx,
  input  logic [XLEN-1:0]              evt_rs1_val,
  input  logic [XLEN-1:0]              evt_rs2_val,
  input  logic                         cnt_clr,
  output logic                         log_vld,
  input  logic                         log_rdy,
  output logic [SEQ_W-1:0]             log_seq,
  output logic [SCR1_TB_EVT_IDX_W-1:0] log_rs1_idx,
  output logic [SCR1_TB_EVT_IDX_W-1:0] log_rs2_idx,
  output logic [XLEN-1:0]              log_rs1_val,
  output logic [XLEN-1:0]              log_rs2_val,
  output logic [CNT_W-1:0]             evt_cnt,
  output logic [CNT_W-1:0]             drop_cnt,
  output logic                         ovf_sticky
);

  typedef struct packed {
    logic [SEQ_W-1:0]             seq;
    logic [SCR1_TB_EVT_IDX_W-1:0] rs1_idx;
    logic [SCR1_TB_EVT_IDX_W-1:0] rs2_idx;
    logic [XLEN-1:0]              rs1_val;
    logic [XLEN-1:0]              rs2_val;
  } entry_t;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             drop;
  logic [SEQ_W-1:0] seq_q, seq_d, seq_wr;
  logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d, evt_base;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             ovf_q, ovf_d;
  entry_t           wr_entry;
  entry_t           head;

  assign pop  = !empty && log_rdy;
  assign push = evt_vld && (!full || pop);
  assign drop = evt_vld && full && !pop;

  // A clear in the same cycle as a push restarts numbering at that push
  assign seq_wr   = cnt_clr ? '0 : seq_q;
  assign evt_base = cnt_clr ? '0 : evt_cnt_q;

  assign wr_entry = '{seq: seq_wr, rs1_idx: evt_rs1_idx, rs2_idx: evt_rs2_idx,
                      rs1_val: evt_rs1_val, rs2_val: evt_rs2_val};

  always_comb begin
    seq_d      = seq_wr;
    evt_cnt_d  = evt_base;
    drop_cnt_d = drop_cnt_q;
    ovf_d      = ovf_q;
    if (push) begin
      seq_d = seq_wr + SEQ_W'(1);
      if (!(&evt_base)) evt_cnt_d = evt_base + CNT_W'(1);
    end
    if (cnt_clr) begin
      drop_cnt_d = '0;
      ovf_d      = 1'b0;
    end else if (drop) begin
      if (!(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_q      <= '0;
      evt_cnt_q  <= '0;
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      seq_q      <= seq_d;
      evt_cnt_q  <= evt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  scr1_tb_evt_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign log_vld     = !empty;
  assign log_seq     = head.seq;
  assign log_rs1_idx = head.rs1_idx;
  assign log_rs2_idx = head.rs2_idx;
  assign log_rs1_val = head.rs1_val;
  assign log_rs2_val = head.rs2_val;
  assign evt_cnt     = evt_cnt_q;
  assign drop_cnt    = drop_cnt_q;
  assign ovf_sticky  = ovf_q;

endmodule

// File: tb/tb_scr1_tb_add_evt_buf.sv
// Directed bench: default-width buffer plus a narrow (SEQ_W=4, CNT_W=5) copy for wrap/saturation.
module tb_scr1_tb_add_evt_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        evt_vld;
  logic [4:0]  evt_rs1_idx, evt_rs2_idx;
  logic [31:0] evt_rs1_val, evt_rs2_val;
  logic        cnt_clr;
  logic        log_rdy;

  logic        log_vld;
  logic [15:0] log_seq;
  logic [4:0]  log_rs1_idx, log_rs2_idx;
  logic [31:0] log_rs1_val, log_rs2_val;
  logic [31:0] evt_cnt, drop_cnt;
  logic        ovf_sticky;

  logic        n_log_vld;
  logic [3:0]  n_log_seq;
  logic [4:0]  n_log_rs1_idx, n_log_rs2_idx;
  logic [31:0] n_log_rs1_val, n_log_rs2_val;
  logic [4:0]  n_evt_cnt, n_drop_cnt;
  logic        n_ovf_sticky;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scr1_tb_add_evt_buf dut (
    .clk(clk), .rst(rst), .evt_vld(evt_vld), .evt_rs1_idx(evt_rs1_idx),
    .evt_rs2_idx(evt_rs2_idx), .evt_rs1_val(evt_rs1_val), .evt_rs2_val(evt_rs2_val),
    .cnt_clr(cnt_clr), .log_vld(log_vld), .log_rdy(log_rdy), .log_seq(log_seq),
    .log_rs1_idx(log_rs1_idx), .log_rs2_idx(log_rs2_idx), .log_rs1_val(log_rs1_val),
    .log_rs2_val(log_rs2_val), .evt_cnt(evt_cnt), .drop_cnt(drop_cnt),
    .ovf_sticky(ovf_sticky)
  );

  scr1_tb_add_evt_buf #(.DEPTH(8), .XLEN(32), .SEQ_W(4), .CNT_W(5)) dut_n (
    .clk(clk), .rst(rst), .evt_vld(evt_vld), .evt_rs1_idx(evt_rs1_idx),
    .evt_rs2_idx(evt_rs2_idx), .evt_rs1_val(evt_rs1_val), .evt_rs2_val(evt_rs2_val),
    .cnt_clr(cnt_clr), .log_vld(n_log_vld), .log_rdy(log_rdy), .log_seq(n_log_seq),
    .log_rs1_idx(n_log_rs1_idx), .log_rs2_idx(n_log_rs2_idx), .log_rs1_val(n_log_rs1_val),
    .log_rs2_val(n_log_rs2_val), .evt_cnt(n_evt_cnt), .drop_cnt(n_drop_cnt),
    .ovf_sticky(n_ovf_sticky)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Event k carries rs1=k+1, rs2=k+2, rs1_val=5+k, rs2_val=7+k
  task automatic set_evt(input int k);
    evt_vld     = 1'b1;
    evt_rs1_idx = 5'(k + 1);
    evt_rs2_idx = 5'(k + 2);
    evt_rs1_val = 32'(5 + k);
    evt_rs2_val = 32'(7 + k);
  endtask

  task automatic test_reset();
    rst = 1'b1; evt_vld = 1'b0; cnt_clr = 1'b0; log_rdy = 1'b0;
    evt_rs1_idx = '0; evt_rs2_idx = '0; evt_rs1_val = '0; evt_rs2_val = '0;
    step(); step();
    rst = 1'b0;
    step();
    checks++;
    if (log_vld !== 1'b0 || log_seq !== 16'd0 || log_rs1_idx !== 5'd0 || log_rs2_idx !== 5'd0 ||
        log_rs1_val !== 32'd0 || log_rs2_val !== 32'd0 || evt_cnt !== 32'd0 ||
        drop_cnt !== 32'd0 || ovf_sticky !== 1'b0 || n_log_vld !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: vld=%b seq=%0d rs1=%0d val=%0d evt=%0d drop=%0d ovf=%b, required all 0",
               log_vld, log_seq, log_rs1_idx, log_rs1_val, evt_cnt, drop_cnt, ovf_sticky);
    end
  endtask

  task automatic test_basic();
    test_reset();
    log_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_evt(k);
      step();
      checks++;
      if (log_vld !== 1'b1 || log_seq !== 16'(k) || log_rs1_idx !== 5'(k + 1) ||
          log_rs2_idx !== 5'(k + 2) || log_rs1_val !== 32'(5 + k) || log_rs2_val !== 32'(7 + k)) begin
        errors++;
        $display("FAIL basic_head[%0d]: vld=%b seq=%0d rs1=%0d rs2=%0d v1=%0d v2=%0d, required 1/%0d/%0d/%0d/%0d/%0d",
                 k, log_vld, log_seq, log_rs1_idx, log_rs2_idx, log_rs1_val, log_rs2_val,
                 k, k + 1, k + 2, 5 + k, 7 + k);
      end
    end
    evt_vld = 1'b0;
    step();
    checks++;
    if (log_vld !== 1'b0 || evt_cnt !== 32'd3 || drop_cnt !== 32'd0) begin
      errors++;
      $display("FAIL basic_counts: vld=%b evt=%0d drop=%0d, required 0/3/0", log_vld, evt_cnt, drop_cnt);
    end
  endtask

  task automatic test_overflow();
    test_reset();
    log_rdy = 1'b0;
    for (int k = 0; k < 10; k++) begin
      set_evt(k);
      step();
    end
    evt_vld = 1'b0;
    checks++;
    if (evt_cnt !== 32'd8 || drop_cnt !== 32'd2 || ovf_sticky !== 1'b1) begin
      errors++;
      $display("FAIL overflow_counts: evt=%0d drop=%0d ovf=%b, required 8/2/1", evt_cnt, drop_cnt, ovf_sticky);
    end
    log_rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (log_vld !== 1'b1 || log_seq !== 16'(k) || log_rs1_val !== 32'(5 + k)) begin
        errors++;
        $display("FAIL overflow_drain[%0d]: vld=%b seq=%0d v1=%0d, required 1/%0d/%0d",
                 k, log_vld, log_seq, log_rs1_val, k, 5 + k);
      end
      step();
    end
    checks++;
    if (log_vld !== 1'b0 || ovf_sticky !== 1'b1) begin
      errors++;
      $display("FAIL overflow_empty: vld=%b ovf=%b, required 0/1", log_vld, ovf_sticky);
    end
  endtask

  task automatic test_full_push_pop();
    test_reset();
    log_rdy = 1'b0;
    for (int k = 0; k < 8; k++) begin
      set_evt(k);
      step();
    end
    set_evt(8);
    log_rdy = 1'b1;
    step();
    evt_vld = 1'b0;
    checks++;
    if (drop_cnt !== 32'd0 || ovf_sticky !== 1'b0 || evt_cnt !== 32'd9 || log_seq !== 16'd1) begin
      errors++;
      $display("FAIL fullpp_counts: drop=%0d ovf=%b evt=%0d head=%0d, required 0/0/9/1",
               drop_cnt, ovf_sticky, evt_cnt, log_seq);
    end
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if (log_vld !== 1'b1 || log_seq !== 16'(k) || log_rs2_val !== 32'(7 + k)) begin
        errors++;
        $display("FAIL fullpp_drain[%0d]: vld=%b seq=%0d v2=%0d, required 1/%0d/%0d",
                 k, log_vld, log_seq, log_rs2_val, k, 7 + k);
      end
      step();
    end
    checks++;
    if (log_vld !== 1'b0) begin
      errors++;
      $display("FAIL fullpp_empty: vld=%b, required 0", log_vld);
    end
  endtask

  task automatic test_hold();
    test_reset();
    log_rdy = 1'b0;
    set_evt(20);
    step();
    set_evt(21);
    step();
    evt_vld = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (log_vld !== 1'b1 || log_seq !== 16'd0 || log_rs1_idx !== 5'd21 || log_rs2_idx !== 5'd22 ||
          log_rs1_val !== 32'd25 || log_rs2_val !== 32'd27) begin
        errors++;
        $display("FAIL hold[%0d]: vld=%b seq=%0d rs1=%0d rs2=%0d v1=%0d v2=%0d, required 1/0/21/22/25/27",
                 c, log_vld, log_seq, log_rs1_idx, log_rs2_idx, log_rs1_val, log_rs2_val);
      end
      step();
    end
    log_rdy = 1'b1;
    step();
    log_rdy = 1'b0;
    checks++;
    if (log_vld !== 1'b1 || log_seq !== 16'd1 || log_rs1_val !== 32'd26) begin
      errors++;
      $display("FAIL hold_pop: vld=%b seq=%0d v1=%0d, required 1/1/26", log_vld, log_seq, log_rs1_val);
    end
  endtask

  task automatic test_seq_wrap();
    test_reset();
    log_rdy = 1'b1;
    for (int k = 0; k < 20; k++) begin
      set_evt(k);
      step();
      checks++;
      if (n_log_vld !== 1'b1 || n_log_seq !== 4'(k % 16)) begin
        errors++;
        $display("FAIL seq_wrap[%0d]: vld=%b seq=%0d, required 1/%0d", k, n_log_vld, n_log_seq, k % 16);
      end
    end
    evt_vld = 1'b0;
    step();
    checks++;
    if (n_evt_cnt !== 5'd20 || evt_cnt !== 32'd20) begin
      errors++;
      $display("FAIL seq_wrap_cnt: narrow=%0d wide=%0d, required 20/20", n_evt_cnt, evt_cnt);
    end
    // 20 more pushes push the 5-bit counter past all-ones; it must stick at 31
    log_rdy = 1'b1;
    for (int k = 0; k < 20; k++) begin
      set_evt(k);
      step();
    end
    evt_vld = 1'b0;
    checks++;
    if (n_evt_cnt !== 5'd31 || evt_cnt !== 32'd40) begin
      errors++;
      $display("FAIL evt_cnt_sat: narrow=%0d wide=%0d, required 31/40", n_evt_cnt, evt_cnt);
    end
  endtask

  task automatic test_clr_and_rst();
    test_reset();
    log_rdy = 1'b0;
    set_evt(0); step();
    set_evt(1); step();
    set_evt(9);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    evt_vld = 1'b0;
    checks++;
    if (evt_cnt !== 32'd1 || drop_cnt !== 32'd0 || ovf_sticky !== 1'b0 ||
        log_vld !== 1'b1 || log_seq !== 16'd0 || log_rs1_val !== 32'd5) begin
      errors++;
      $display("FAIL clr_counts: evt=%0d drop=%0d ovf=%b vld=%b head_seq=%0d v1=%0d, required 1/0/0/1/0/5",
               evt_cnt, drop_cnt, ovf_sticky, log_vld, log_seq, log_rs1_val);
    end
    log_rdy = 1'b1;
    step(); step();
    log_rdy = 1'b0;
    checks++;
    if (log_vld !== 1'b1 || log_seq !== 16'd0 || log_rs1_val !== 32'd14 || log_rs1_idx !== 5'd10) begin
      errors++;
      $display("FAIL clr_entry: vld=%b seq=%0d v1=%0d rs1=%0d, required 1/0/14/10",
               log_vld, log_seq, log_rs1_val, log_rs1_idx);
    end
    set_evt(3); step();
    evt_vld = 1'b0;
    // Asynchronous reset checked before any clock edge arrives
    #2 rst = 1'b1;
    #1;
    checks++;
    if (log_vld !== 1'b0 || evt_cnt !== 32'd0 || drop_cnt !== 32'd0 || ovf_sticky !== 1'b0 ||
        log_seq !== 16'd0 || log_rs1_val !== 32'd0) begin
      errors++;
      $display("FAIL async_rst: vld=%b evt=%0d drop=%0d ovf=%b seq=%0d v1=%0d, required all 0",
               log_vld, evt_cnt, drop_cnt, ovf_sticky, log_seq, log_rs1_val);
    end
    step();
    rst = 1'b0;
    set_evt(4); step();
    evt_vld = 1'b0;
    checks++;
    if (log_vld !== 1'b1 || log_seq !== 16'd0 || log_rs1_val !== 32'd9 || evt_cnt !== 32'd1) begin
      errors++;
      $display("FAIL post_rst_evt: vld=%b seq=%0d v1=%0d evt=%0d, required 1/0/9/1",
               log_vld, log_seq, log_rs1_val, evt_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_hold();
    test_seq_wrap();
    test_clr_and_rst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
